bram_port_arbiter: RTL and testbench



---
 rtl/bram_port_arbiter.sv | 104 ++++++++++
 tb/tb_bram_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin arbiter sharing one BRAM port among req_n valid/ready requesters
// ports: aclk/aresetn clock and async active-low reset; req_* per-requester command channel;
//        rsp_valid/rsp_data read return; bram_* registered BRAM port drive; busy = read in flight
module bram_port_arbiter #(
  parameter int req_n = 4,
  parameter int addr_width = 10,
  parameter int data_width = 32,
  parameter int bram_read_latency = 1,
  parameter int simulation_delay = 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [req_n-1:0]            req_valid,
  output logic [req_n-1:0]            req_ready,
  input  logic [req_n-1:0]            req_wen,
  input  logic [req_n-1:0]            req_lock,
  input  logic [req_n*addr_width-1:0] req_addr,
  input  logic [req_n*data_width-1:0] req_din,
  output logic [req_n-1:0]            rsp_valid,
  output logic [data_width-1:0]       rsp_data,
  output logic                        bram_en,
  output logic                        bram_we,
  output logic [addr_width-1:0]       bram_addr,
  output logic [data_width-1:0]       bram_din,
  input  logic [data_width-1:0]       bram_dout,
  output logic                        busy
);
  localparam int id_w = $clog2(req_n - 1) + 1;
  localparam int tl = bram_read_latency;
  logic [id_w-1:0] rr_ptr, lock_id, gnt_id;
  logic lock_vld, hs, sel_wen, sel_lock;
  logic [addr_width-1:0] sel_addr;
  logic [data_width-1:0] sel_din;
  logic [tl:0] tag_v;
  logic [id_w-1:0] tag_id [tl+1];
  logic unused_dly;
  int p;
  assign unused_dly = |simulation_delay;
  // scanning from the lowest priority upward lets the last hit be the winner
  always_comb begin
    gnt_id = lock_id;
    hs = 1'b0;
    p = 0;
    if (lock_vld) begin
      for (int i = 0; i < req_n; i++) if (lock_id == id_w'(i) && req_valid[i]) hs = 1'b1;
    end else begin
      for (int k = req_n - 1; k >= 0; k--) begin
        p = int'(rr_ptr) + k;
        p = p >= req_n ? p - req_n : p;
        for (int i = 0; i < req_n; i++) if (p == i && req_valid[i]) begin
          hs = 1'b1;
          gnt_id = id_w'(i);
        end
      end
    end
    hs = hs & aresetn;
  end
  always_comb begin
    req_ready = '0;
    sel_wen = 1'b0;
    sel_lock = 1'b0;
    sel_addr = '0;
    sel_din = '0;
    for (int i = 0; i < req_n; i++) if (hs && gnt_id == id_w'(i)) begin
      req_ready[i] = 1'b1;
      sel_wen = req_wen[i];
      sel_lock = req_lock[i];
      sel_addr = req_addr[i*addr_width +: addr_width];
      sel_din = req_din[i*data_width +: data_width];
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr <= '0;
      lock_vld <= 1'b0;
      lock_id <= '0;
      bram_en <= 1'b0;
      bram_we <= 1'b0;
      bram_addr <= '0;
      bram_din <= '0;
      tag_v <= '0;
      for (int i = 0; i <= tl; i++) tag_id[i] <= '0;
    end else begin
      bram_en <= hs;
      bram_we <= hs & sel_wen;
      if (hs) begin
        bram_addr <= sel_addr;
        bram_din <= sel_din;
        lock_vld <= sel_lock;
        lock_id <= sel_lock ? gnt_id : lock_id;
        rr_ptr <= sel_lock ? rr_ptr : gnt_id == id_w'(req_n - 1) ? '0 : gnt_id + 1'b1;
      end
      tag_v <= {tag_v[tl-1:0], hs & ~sel_wen};
      tag_id[0] <= gnt_id;
      for (int i = 1; i <= tl; i++) tag_id[i] <= tag_id[i-1];
    end
  end
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < req_n; i++) rsp_valid[i] = tag_v[tl] && tag_id[tl] == id_w'(i);
  end
  assign rsp_data = bram_dout;
  assign busy = |tag_v;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: checks the arbiter at read latency 1 and 2 side by side against a reference memory
module tb_bram_port_arbiter;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [3:0] req_valid = '1, req_wen = '0, req_lock = '0;
  logic [9:0] addr_i [4];
  logic [31:0] din_i [4];
  logic [39:0] req_addr;
  logic [127:0] req_din;
  logic [3:0] ready1, ready2, rsp1, rsp2;
  logic [31:0] rdata1, rdata2, bdin1, bdin2, dout1, dout2, d2a;
  logic [9:0] baddr1, baddr2;
  logic en1, en2, we1, we2, busy1, busy2;
  logic [31:0] m1 [1024];
  logic [31:0] m2 [1024];
  logic [31:0] mem_ref [1024];
  int checks = 0, errors = 0, cyc = 0;
  logic prev_hs = 1'b0;
  typedef struct {int id; logic [31:0] data; int due;} rsp_t;
  rsp_t q1[$], q2[$];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;
  always_comb for (int i = 0; i < 4; i++) begin
    req_addr[i*10 +: 10] = addr_i[i];
    req_din[i*32 +: 32] = din_i[i];
  end

  bram_port_arbiter #(.req_n(4), .addr_width(10), .data_width(32), .bram_read_latency(1)) u1 (
    .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(ready1), .req_wen(req_wen),
    .req_lock(req_lock), .req_addr(req_addr), .req_din(req_din), .rsp_valid(rsp1), .rsp_data(rdata1),
    .bram_en(en1), .bram_we(we1), .bram_addr(baddr1), .bram_din(bdin1), .bram_dout(dout1), .busy(busy1));
  bram_port_arbiter #(.req_n(4), .addr_width(10), .data_width(32), .bram_read_latency(2)) u2 (
    .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(ready2), .req_wen(req_wen),
    .req_lock(req_lock), .req_addr(req_addr), .req_din(req_din), .rsp_valid(rsp2), .rsp_data(rdata2),
    .bram_en(en2), .bram_we(we2), .bram_addr(baddr2), .bram_din(bdin2), .bram_dout(dout2), .busy(busy2));

  // BRAM models: latency 1 has no output register, latency 2 adds one
  always @(posedge aclk) begin
    if (en1) begin
      if (we1) m1[baddr1] <= bdin1;
      else dout1 <= m1[baddr1];
    end
    if (en2) begin
      if (we2) m2[baddr2] <= bdin2;
      else d2a <= m2[baddr2];
    end
    dout2 <= d2a;
  end

  // scoreboard consumer: every cycle out of reset, the response either matches the queue head or is absent
  always @(negedge aclk) begin
    logic [3:0] ev;
    if (!aresetn) begin
      q1.delete();
      q2.delete();
    end else begin
      checks++;
      if (q1.size() > 0 && q1[0].due == cyc) begin
        ev = 4'(1) << q1[0].id;
        if (rsp1 !== ev || rdata1 !== q1[0].data) begin
          errors++;
          $display("FAIL rsp_L1 cyc=%0d valid=%b data=%h expected valid=%b data=%h", cyc, rsp1, rdata1, ev, q1[0].data);
        end
        void'(q1.pop_front());
      end else if (rsp1 !== 4'b0) begin
        errors++;
        $display("FAIL rsp_L1_idle cyc=%0d valid=%b expected 0000", cyc, rsp1);
      end
      checks++;
      if (q2.size() > 0 && q2[0].due == cyc) begin
        ev = 4'(1) << q2[0].id;
        if (rsp2 !== ev || rdata2 !== q2[0].data) begin
          errors++;
          $display("FAIL rsp_L2 cyc=%0d valid=%b data=%h expected valid=%b data=%h", cyc, rsp2, rdata2, ev, q2[0].data);
        end
        void'(q2.pop_front());
      end else if (rsp2 !== 4'b0) begin
        errors++;
        $display("FAIL rsp_L2_idle cyc=%0d valid=%b expected 0000", cyc, rsp2);
      end
    end
  end

  // one clock of stimulus with the expected grant e; reads are queued with their due cycle
  task automatic cycle(input logic [3:0] v, input logic [3:0] w, input logic [3:0] l, input logic [3:0] e, input string nm);
    rsp_t r;
    req_valid = v;
    req_wen = w;
    req_lock = l;
    @(negedge aclk);
    checks++;
    if (ready1 !== e || ready2 !== e) begin
      errors++;
      $display("FAIL %s ready L1=%b L2=%b expected %b", nm, ready1, ready2, e);
    end
    checks++;
    if (en1 !== prev_hs || en2 !== prev_hs) begin
      errors++;
      $display("FAIL %s bram_en L1=%b L2=%b expected %b", nm, en1, en2, prev_hs);
    end
    prev_hs = |e;
    for (int g = 0; g < 4; g++) if (e[g]) begin
      if (w[g]) mem_ref[addr_i[g]] = din_i[g];
      else begin
        r.id = g;
        r.data = mem_ref[addr_i[g]];
        r.due = cyc + 2;
        q1.push_back(r);
        r.due = cyc + 3;
        q2.push_back(r);
      end
    end
    @(posedge aclk);
    #1;
    req_valid = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(4'b0, 4'b0, 4'b0, 4'b0, "idle");
  endtask

  task automatic test_reset();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({ready1, ready2, rsp1, rsp2, en1, en2, we1, we2, baddr1, baddr2, bdin1, bdin2, busy1, busy2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b/%b rsp=%b/%b en=%b/%b busy=%b/%b expected all 0",
               ready1, ready2, rsp1, rsp2, en1, en2, busy1, busy2);
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) addr_i[i] = 10'h10 + 10'(i);
    for (int k = 0; k < 8; k++) cycle(4'hF, 4'h0, 4'h0, 4'(1) << (k % 4), "rr");
    idle(4);
  endtask

  task automatic test_lock();
    addr_i[1] = 10'h11;
    cycle(4'b0010, 4'h0, 4'h0, 4'b0010, "lk_pre");
    addr_i[2] = 10'h20;
    cycle(4'hF, 4'h0, 4'b0100, 4'b0100, "lk_b1");
    cycle(4'b1011, 4'h0, 4'h0, 4'b0000, "lk_holder_idle");
    addr_i[2] = 10'h21;
    cycle(4'hF, 4'h0, 4'b0100, 4'b0100, "lk_b2");
    addr_i[2] = 10'h22;
    cycle(4'hF, 4'h0, 4'b0000, 4'b0100, "lk_b3");
    cycle(4'hF, 4'h0, 4'h0, 4'b1000, "lk_next");
    idle(4);
  endtask

  task automatic test_write_then_read();
    addr_i[1] = 10'd5;
    din_i[1] = 32'hDEADBEEF;
    cycle(4'b0010, 4'b0010, 4'h0, 4'b0010, "wtr_write");
    cycle(4'b0010, 4'b0000, 4'h0, 4'b0010, "wtr_read");
    idle(4);
  endtask

  task automatic test_reset_mid_flight();
    addr_i[0] = 10'h40;
    cycle(4'b0001, 4'h0, 4'h0, 4'b0001, "mf_accept");
    checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL mf_busy_before busy=%b/%b expected 1/1", busy1, busy2);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if ({busy1, busy2, rsp1, rsp2, en1, en2} !== '0) begin
      errors++;
      $display("FAIL mf_reset busy=%b/%b rsp=%b/%b en=%b/%b expected all 0", busy1, busy2, rsp1, rsp2, en1, en2);
    end
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    prev_hs = 1'b0;
    idle(4);
  endtask

  task automatic test_sparse();
    for (int k = 0; k < 4; k++) begin
      addr_i[3] = 10'h30 + 10'(k);
      cycle(4'b1000, 4'h0, 4'h0, 4'b1000, "sp_accept");
      for (int j = 1; j <= (k == 3 ? 4 : 2); j++) begin
        req_valid = '0;
        @(negedge aclk);
        checks++;
        if (en1 !== (j == 1) || en2 !== (j == 1) || busy1 !== (j <= 2) || busy2 !== (j <= 3)) begin
          errors++;
          $display("FAIL sp_gap%0d en=%b/%b busy=%b/%b expected en=%b busy=%b/%b",
                   j, en1, en2, busy1, busy2, j == 1, j <= 2, j <= 3);
        end
        @(posedge aclk);
        #1;
      end
      prev_hs = 1'b0;
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      m1[a] = 32'hA500_0000 | 32'(a);
      m2[a] = 32'hA500_0000 | 32'(a);
      mem_ref[a] = 32'hA500_0000 | 32'(a);
    end
    for (int i = 0; i < 4; i++) begin
      addr_i[i] = '0;
      din_i[i] = 32'h1111_0000 * 32'(i + 1);
    end
    test_reset();
    test_round_robin();
    test_lock();
    test_write_then_read();
    test_reset_mid_flight();
    test_sparse();
    idle(3);
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain pending L1=%0d L2=%0d expected 0/0", q1.size(), q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
